// File: rtl/ula_pkg.sv
// ula_pkg: op codes and FSM state encoding for ula_multdiv.
// The DIV state exists only when ULA_DIV_EN is defined.
package ula_pkg;
  localparam logic [3:0] ULA_ADD   = 4'h0;
  localparam logic [3:0] ULA_SUB   = 4'h1;
  localparam logic [3:0] ULA_AND   = 4'h2;
  localparam logic [3:0] ULA_OR    = 4'h3;
  localparam logic [3:0] ULA_XOR   = 4'h4;
  localparam logic [3:0] ULA_NOR   = 4'h5;
  localparam logic [3:0] ULA_SLT   = 4'h6;
  localparam logic [3:0] ULA_SLTU  = 4'h7;
  localparam logic [3:0] ULA_MULT  = 4'h8;
  localparam logic [3:0] ULA_MULTU = 4'h9;
  localparam logic [3:0] ULA_DIV   = 4'hA;
  localparam logic [3:0] ULA_DIVU  = 4'hB;
  localparam logic [3:0] ULA_MFHI  = 4'hC;
  localparam logic [3:0] ULA_MFLO  = 4'hD;
  localparam logic [3:0] ULA_MTHI  = 4'hE;
  localparam logic [3:0] ULA_MTLO  = 4'hF;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef ULA_DIV_EN
  localparam logic [1:0] ST_DIV  = 2'd2;
`endif
  localparam logic [1:0] ST_FIN  = 2'd3;
endpackage

// File: rtl/ula_iter_core.sv
// ula_iter_core: shift-add multiplier / restoring divider on operand magnitudes, one bit per cycle.
// Divider datapath present only with ULA_DIV_EN; hi/lo carry the sign-corrected result.
module ula_iter_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] mag_q, mag_d, ma, mb;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, neg_q, neg_d;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ULA_DIV_EN
  logic div_q, div_d, rneg_q, rneg_d;
  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] diff;
`else
  logic unused_div;
  assign unused_div = is_div;
`endif
  assign busy = run_q;
  assign last = run_q && cnt_q == CW'(WIDTH-1);
  always_comb begin
    ma = is_signed && a[WIDTH-1] ? -a : a;
    mb = is_signed && b[WIDTH-1] ? -b : b;
    sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mag_q} : '0);
    prod = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    acc_d = acc_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    run_d = run_q;
    neg_d = neg_q;
`ifdef ULA_DIV_EN
    div_d = div_q;
    rneg_d = rneg_q;
    sh = acc_q << 1;
    diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, mag_q};
    hi = div_q ? (rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    lo = div_q ? (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[WIDTH-1:0];
`else
    hi = prod[2*WIDTH-1:WIDTH];
    lo = prod[WIDTH-1:0];
`endif
    if (load) begin
      run_d = 1'b1;
      cnt_d = '0;
      neg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ULA_DIV_EN
      div_d = is_div;
      rneg_d = is_signed && a[WIDTH-1];
      acc_d = {{(WIDTH+1){1'b0}}, is_div ? ma : mb};
      mag_d = is_div ? mb : ma;
`else
      acc_d = {{(WIDTH+1){1'b0}}, mb};
      mag_d = ma;
`endif
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
      run_d = !last;
`ifdef ULA_DIV_EN
      acc_d = div_q ? (diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1}) : {sum, acc_q[WIDTH-1:0]} >> 1;
`else
      acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      neg_q <= 1'b0;
`ifdef ULA_DIV_EN
      div_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      neg_q <= neg_d;
`ifdef ULA_DIV_EN
      div_q <= div_d;
      rneg_q <= rneg_d;
`endif
    end
  end
endmodule

// File: rtl/ula_multdiv.sv
// ula_multdiv: sequential ALU with single-cycle ops, iterative MULT/DIV into HI/LO and start/busy/done.
// Define ULA_DIV_EN to build the divider; otherwise DIV/DIVU complete in one cycle with no effect.
module ula_multdiv import ula_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       ula_op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d, alu, sum_ab, dif_ab, core_hi, core_lo;
  logic zero_q, zero_d, ovf_q, ovf_d, done_q, done_d, dz_q, dz_d;
  logic alu_ovf, single, core_load, core_busy, core_last;
`ifdef ULA_DIV_EN
  logic dzc_q, dzc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
`endif
  assign busy = state_q != ST_IDLE || core_busy;
  assign done = done_q;
  assign result = res_q;
  assign zero = zero_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;
  assign sum_ab = a_in + b_in;
  assign dif_ab = a_in - b_in;
  assign single = !ula_op[3] || ula_op[3:2] == 2'b11;
  ula_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .reset(reset), .load(core_load), .is_signed(!ula_op[0]), .is_div(ula_op[1]),
    .a(a_in), .b(b_in), .busy(core_busy), .last(core_last), .hi(core_hi), .lo(core_lo)
  );
  always_comb begin
    case (ula_op)
      ULA_ADD:  alu = sum_ab;
      ULA_SUB:  alu = dif_ab;
      ULA_AND:  alu = a_in & b_in;
      ULA_OR:   alu = a_in | b_in;
      ULA_XOR:  alu = a_in ^ b_in;
      ULA_NOR:  alu = ~(a_in | b_in);
      ULA_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      ULA_SLTU: alu = {{(WIDTH-1){1'b0}}, a_in < b_in};
      ULA_MFHI: alu = hi_q;
      ULA_MFLO: alu = lo_q;
      default:  alu = a_in;
    endcase
    alu_ovf = ula_op == ULA_ADD ? a_in[WIDTH-1] == b_in[WIDTH-1] && sum_ab[WIDTH-1] != a_in[WIDTH-1] :
              ula_op == ULA_SUB ? a_in[WIDTH-1] != b_in[WIDTH-1] && dif_ab[WIDTH-1] != a_in[WIDTH-1] : 1'b0;
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    res_d = res_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    dz_d = dz_q;
    done_d = 1'b0;
    core_load = 1'b0;
`ifdef ULA_DIV_EN
    dzc_d = dzc_q;
    opa_d = opa_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        ovf_d = alu_ovf;
        if (single) begin
          done_d = 1'b1;
          if (ula_op[3:1] != 3'b111) begin
            res_d = alu;
            zero_d = alu == '0;
          end
          hi_d = ula_op == ULA_MTHI ? a_in : hi_q;
          lo_d = ula_op == ULA_MTLO ? a_in : lo_q;
        end else if (!ula_op[1]) begin
          core_load = 1'b1;
          state_d = ST_MUL;
        end else begin
`ifdef ULA_DIV_EN
          dz_d = b_in == '0;
          dzc_d = b_in == '0;
          opa_d = a_in;
          core_load = b_in != '0;
          state_d = b_in == '0 ? ST_FIN : ST_DIV;
`else
          done_d = 1'b1;
`endif
        end
      end
      ST_MUL: state_d = core_last ? ST_FIN : ST_MUL;
`ifdef ULA_DIV_EN
      ST_DIV: state_d = core_last ? ST_FIN : ST_DIV;
      default: begin
        hi_d = dzc_q ? opa_q : core_hi;
        lo_d = dzc_q ? '1 : core_lo;
        state_d = ST_IDLE;
        done_d = 1'b1;
      end
`else
      default: begin
        hi_d = core_hi;
        lo_d = core_lo;
        state_d = ST_IDLE;
        done_d = 1'b1;
      end
`endif
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      zero_q <= 1'b1;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
`ifdef ULA_DIV_EN
      dzc_q <= 1'b0;
      opa_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      res_q <= res_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      dz_q <= dz_d;
`ifdef ULA_DIV_EN
      dzc_q <= dzc_d;
      opa_q <= opa_d;
`endif
    end
  end
endmodule

// File: tb/tb_ula_multdiv.sv
// tb_ula_multdiv: directed and random ops against an arithmetic reference model of ula_multdiv.
module tb_ula_multdiv;
  import ula_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [3:0] ula_op = '0;
  logic busy, done, zero, overflow, div_zero;
  logic [31:0] result;
  logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
  logic m_zero = 1'b1, m_ovf = 1'b0, m_dz = 1'b0;
  int n_chk = 0, n_fail = 0;

  ula_multdiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .ula_op(ula_op), .start(start),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 1;
    m_ovf = 1'b0;
    case (op)
      ULA_ADD:  begin m_res = a + b; p = sa + sb; m_ovf = p != longint'($signed(m_res)); end
      ULA_SUB:  begin m_res = a - b; p = sa - sb; m_ovf = p != longint'($signed(m_res)); end
      ULA_AND:  m_res = a & b;
      ULA_OR:   m_res = a | b;
      ULA_XOR:  m_res = a ^ b;
      ULA_NOR:  m_res = ~(a | b);
      ULA_SLT:  m_res = sa < sb ? 32'd1 : 32'd0;
      ULA_SLTU: m_res = a < b ? 32'd1 : 32'd0;
      ULA_MULT: begin p = sa * sb; {m_hi, m_lo} = p; lat = 34; end
      ULA_MULTU: begin up = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = up; lat = 34; end
`ifdef ULA_DIV_EN
      ULA_DIV, ULA_DIVU: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1; m_dz = 1'b1; lat = 2;
        end else begin
          m_dz = 1'b0; lat = 34;
          if (op == ULA_DIV) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
          else begin m_lo = a / b; m_hi = a % b; end
        end
      end
`endif
      ULA_MFHI: m_res = m_hi;
      ULA_MFLO: m_res = m_lo;
      ULA_MTHI: m_hi = a;
      ULA_MTLO: m_lo = a;
      default: ;
    endcase
    m_zero = m_res == 0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    int lat, elat;
    logic bsy;
    model(op, a, b, elat);
    @(negedge clk);
    a_in = a; b_in = b; ula_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; bsy = busy;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == inj) begin ula_op = ULA_ADD; a_in = 32'h0000_1234; b_in = 32'h1; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0; lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("busy", 32'(bsy), 32'(elat > 1));
    chk("result", result, m_res);
    chk("zero", 32'(zero), 32'(m_zero));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("div_zero", 32'(div_zero), 32'(m_dz));
  endtask

  task automatic chk_hilo();
    do_op(ULA_MFHI, 32'h0, 32'h0, 0);
    do_op(ULA_MFLO, 32'h0, 32'h0, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_div_zero", 32'(div_zero), 32'h0);
    @(negedge clk) reset = 1'b0;
    chk_hilo();
    do_op(ULA_ADD, 32'h7FFF_FFFF, 32'h1, 0);
    do_op(ULA_SUB, 32'h5, 32'h5, 0);
    do_op(ULA_SUB, 32'h8000_0000, 32'h1, 0);
    do_op(ULA_SLT, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(ULA_SLTU, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(ULA_NOR, 32'h0F0F_0000, 32'h0000_00F0, 0);
    do_op(ULA_MULT, 32'hFFFF_FFFE, 32'h3, 0);
    chk_hilo();
    do_op(ULA_DIV, 32'hFFFF_FFF9, 32'h2, 0);
    chk_hilo();
    do_op(ULA_DIVU, 32'h7, 32'h0, 0);
    chk_hilo();
    do_op(ULA_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk_hilo();
    do_op(ULA_DIVU, 32'hFFFF_FFFF, 32'h10, 0);
    chk_hilo();
    do_op(ULA_MTHI, 32'hCAFE_0001, 32'h0, 0);
    do_op(ULA_MTLO, 32'h0000_BEEF, 32'h0, 0);
    chk_hilo();
    do_op(ULA_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    chk_hilo();
    for (int i = 0; i < 60; i++) do_op(4'($urandom_range(0, 15)), pick(), pick(), 0);
    chk_hilo();
    do_op(ULA_ADD, 32'h1, 32'h2, 0);
    @(negedge clk);
    a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0; ula_op = ULA_MULTU; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_zero", 32'(zero), 32'h1);
    chk("midrst_div_zero", 32'(div_zero), 32'h0);
    @(negedge clk) reset = 1'b0;
    m_hi = '0; m_lo = '0; m_res = '0; m_zero = 1'b1; m_ovf = 1'b0; m_dz = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    chk("midrst_no_done", 32'(seen), 32'h0);
    chk_hilo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
